// File: rtl/ca_code_sequencer.sv
// Sequencer for a GPS C/A code generator: PRN tap lookup, load/run control,
// NCO-driven chip advance strobe, chip/epoch counting and delay-only slews.
`timescale 1ns/1ps
module ca_code_sequencer #(
  parameter int NCO_W  = 32,
  parameter int SLEW_W = 10
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_enable,
  input  logic              i_cfg_valid,
  input  logic [5:0]        i_cfg_prn,
  output logic              o_cfg_ready,
  output logic              o_cfg_err,
  input  logic [NCO_W-1:0]  i_code_rate,
  input  logic              i_slew_valid,
  input  logic [SLEW_W-1:0] i_slew_chips,
  output logic              o_slew_ready,
  output logic [9:0]        o_g1_init,
  output logic [9:0]        o_g2_init,
  output logic [3:0]        o_T0,
  output logic [3:0]        o_T1,
  output logic              o_gen_rst_n,
  output logic              o_gen_adv,
  output logic [9:0]        o_chip_cnt,
  output logic              o_epoch
);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [NCO_W-1:0]    r_nco;
  logic [9:0]          r_chip_cnt;
  logic [SLEW_W-1:0]   r_pending;
  logic                r_gen_adv;
  logic                r_epoch;
  logic                r_cfg_err;
  logic [3:0]          r_t0;
  logic [3:0]          r_t1;

  logic [3:0]          w_tap0;
  logic [3:0]          w_tap1;
  logic                w_prn_legal;
  logic                w_cfg_acc;
  logic                w_cfg_go;
  logic                w_slew_acc;
  logic                w_run;
  logic [NCO_W:0]      w_sum;
  logic                w_carry;
  logic                w_adv;

  // G2 phase-select taps for PRN 1..32
  always_comb begin
    w_tap0 = 4'd0;
    w_tap1 = 4'd0;
    case (i_cfg_prn)
      6'd1:  begin w_tap0 = 4'd2; w_tap1 = 4'd6;  end
      6'd2:  begin w_tap0 = 4'd3; w_tap1 = 4'd7;  end
      6'd3:  begin w_tap0 = 4'd4; w_tap1 = 4'd8;  end
      6'd4:  begin w_tap0 = 4'd5; w_tap1 = 4'd9;  end
      6'd5:  begin w_tap0 = 4'd1; w_tap1 = 4'd9;  end
      6'd6:  begin w_tap0 = 4'd2; w_tap1 = 4'd10; end
      6'd7:  begin w_tap0 = 4'd1; w_tap1 = 4'd8;  end
      6'd8:  begin w_tap0 = 4'd2; w_tap1 = 4'd9;  end
      6'd9:  begin w_tap0 = 4'd3; w_tap1 = 4'd10; end
      6'd10: begin w_tap0 = 4'd2; w_tap1 = 4'd3;  end
      6'd11: begin w_tap0 = 4'd3; w_tap1 = 4'd4;  end
      6'd12: begin w_tap0 = 4'd5; w_tap1 = 4'd6;  end
      6'd13: begin w_tap0 = 4'd6; w_tap1 = 4'd7;  end
      6'd14: begin w_tap0 = 4'd7; w_tap1 = 4'd8;  end
      6'd15: begin w_tap0 = 4'd8; w_tap1 = 4'd9;  end
      6'd16: begin w_tap0 = 4'd9; w_tap1 = 4'd10; end
      6'd17: begin w_tap0 = 4'd1; w_tap1 = 4'd4;  end
      6'd18: begin w_tap0 = 4'd2; w_tap1 = 4'd5;  end
      6'd19: begin w_tap0 = 4'd3; w_tap1 = 4'd6;  end
      6'd20: begin w_tap0 = 4'd4; w_tap1 = 4'd7;  end
      6'd21: begin w_tap0 = 4'd5; w_tap1 = 4'd8;  end
      6'd22: begin w_tap0 = 4'd6; w_tap1 = 4'd9;  end
      6'd23: begin w_tap0 = 4'd1; w_tap1 = 4'd3;  end
      6'd24: begin w_tap0 = 4'd4; w_tap1 = 4'd6;  end
      6'd25: begin w_tap0 = 4'd5; w_tap1 = 4'd7;  end
      6'd26: begin w_tap0 = 4'd6; w_tap1 = 4'd8;  end
      6'd27: begin w_tap0 = 4'd7; w_tap1 = 4'd9;  end
      6'd28: begin w_tap0 = 4'd8; w_tap1 = 4'd10; end
      6'd29: begin w_tap0 = 4'd1; w_tap1 = 4'd6;  end
      6'd30: begin w_tap0 = 4'd2; w_tap1 = 4'd7;  end
      6'd31: begin w_tap0 = 4'd3; w_tap1 = 4'd8;  end
      6'd32: begin w_tap0 = 4'd4; w_tap1 = 4'd9;  end
      default: begin w_tap0 = 4'd0; w_tap1 = 4'd0; end
    endcase
  end

  assign w_prn_legal = (i_cfg_prn != 6'd0) && (i_cfg_prn <= 6'd32);
  assign w_cfg_acc   = i_cfg_valid & o_cfg_ready;
  assign w_cfg_go    = w_cfg_acc & w_prn_legal;
  assign w_slew_acc  = i_slew_valid & o_slew_ready;

  // A cycle that is leaving RUN (disable or restart) must not advance the code
  assign w_run   = (r_state == ST_RUN) && i_enable && !w_cfg_go;
  assign w_sum   = {1'b0, r_nco} + {1'b0, i_code_rate};
  assign w_carry = w_sum[NCO_W];
  assign w_adv   = w_run && w_carry && (r_pending == '0);

  always_comb begin
    w_state_nxt = r_state;
    if (!i_enable) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_cfg_go) w_state_nxt = ST_LOAD;
        ST_LOAD: w_state_nxt = ST_RUN;
        ST_RUN:  if (w_cfg_go) w_state_nxt = ST_LOAD;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_nco      <= '0;
      r_chip_cnt <= '0;
      r_pending  <= '0;
      r_gen_adv  <= 1'b0;
      r_epoch    <= 1'b0;
      r_cfg_err  <= 1'b0;
      r_t0       <= 4'd2;
      r_t1       <= 4'd6;
    end else begin
      r_state   <= w_state_nxt;
      r_cfg_err <= w_cfg_acc & ~w_prn_legal;
      r_gen_adv <= w_adv;
      r_epoch   <= w_adv && (r_chip_cnt == 10'd1022);
      if (w_cfg_go) begin
        r_t0 <= w_tap0;
        r_t1 <= w_tap1;
      end
      if (r_state == ST_LOAD) begin
        r_nco      <= '0;
        r_chip_cnt <= '0;
        r_pending  <= '0;
      end else begin
        if (w_run) begin
          r_nco <= w_sum[NCO_W-1:0];
          if (w_adv) begin
            r_chip_cnt <= (r_chip_cnt == 10'd1022) ? 10'd0 : r_chip_cnt + 10'd1;
          end
          if (w_carry && (r_pending != '0)) begin
            r_pending <= r_pending - SLEW_W'(1);
          end
        end
        // Accept only happens with nothing pending, so it never races the decrement
        if (w_slew_acc) begin
          r_pending <= i_slew_chips;
        end
      end
    end
  end

  assign o_cfg_ready  = (r_state == ST_IDLE) || (r_state == ST_RUN);
  assign o_slew_ready = (r_state == ST_RUN) && (r_pending == '0);
  assign o_cfg_err    = r_cfg_err;
  assign o_g1_init    = 10'h3FF;
  assign o_g2_init    = 10'h3FF;
  assign o_T0         = r_t0;
  assign o_T1         = r_t1;
  assign o_gen_rst_n  = (r_state == ST_RUN);
  assign o_gen_adv    = r_gen_adv;
  assign o_chip_cnt   = r_chip_cnt;
  assign o_epoch      = r_epoch;

endmodule
